rvv_backend_retire_pipe: RTL and testbench

- Parametrised, registered retire stage between ROB and register files.
- Accepts an in-order prefix of up to NUM_RT uops per cycle.
- Writes VRF through a one-cycle registered port with intra-group WAW strobe resolution, and drains XRF writes through an XQ_DEPTH-entry FIFO onto one XRF port.
- Handles traps with a drain state machine and keeps a sticky vxsat flag.

---
 rtl/rvv_backend_retire_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_rvv_backend_retire_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_retire_pipe.sv
// rvv_backend_retire_pipe: registered retire stage between the ROB and the
// vector/scalar register files. Accepts an in-order prefix of up to NUM_RT
// uops per cycle, resolves same-group VRF write-after-write by byte strobe,
// queues scalar writes in a small FIFO, drains on traps before publishing the
// trapping uop's CSR snapshot, and keeps a sticky vxsat flag.
// Optional: define RT_PERF_CNT_EN to add the perf_retired / perf_stall counters.
module rvv_backend_retire_pipe #(
    parameter int unsigned NUM_RT   = 4,
    parameter int unsigned VLEN     = 128,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned VCSR_W   = 32,
    parameter int unsigned XQ_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RT-1:0]             rob2rt_valid,
    input  logic [NUM_RT-1:0]             rob2rt_wtype,
    input  logic [NUM_RT*IDX_W-1:0]       rob2rt_index,
    input  logic [NUM_RT*VLEN-1:0]        rob2rt_data,
    input  logic [NUM_RT*(VLEN/8)-1:0]    rob2rt_strobe,
    input  logic [NUM_RT-1:0]             rob2rt_trap,
    input  logic [NUM_RT-1:0]             rob2rt_vxsat,
    input  logic [NUM_RT*VCSR_W-1:0]      rob2rt_vcsr,
    output logic [NUM_RT-1:0]             rob2rt_ready,
    output logic [NUM_RT-1:0]             rt2vrf_valid,
    output logic [NUM_RT*IDX_W-1:0]       rt2vrf_index,
    output logic [NUM_RT*VLEN-1:0]        rt2vrf_data,
    output logic [NUM_RT*(VLEN/8)-1:0]    rt2vrf_strobe,
    output logic                          rt2xrf_valid,
    output logic [IDX_W-1:0]              rt2xrf_index,
    output logic [XLEN-1:0]               rt2xrf_data,
    input  logic                          rt2xrf_ready,
    output logic                          rt2vcsr_valid,
    output logic [VCSR_W-1:0]             rt2vcsr_data,
    output logic                          vxsat,
    input  logic                          vxsat_clr,
`ifdef RT_PERF_CNT_EN
    output logic [31:0]                   perf_retired,
    output logic [31:0]                   perf_stall,
`endif
    output logic                          trap_busy
);

    localparam int unsigned VLENB = VLEN / 8;
    localparam int unsigned PTR_W = (XQ_DEPTH > 1) ? $clog2(XQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        RT_RUN        = 1'b0,
        RT_TRAP_DRAIN = 1'b1
    } state_t;

    state_t                state;

    logic [IDX_W-1:0]      xq_index [XQ_DEPTH];
    logic [XLEN-1:0]       xq_data  [XQ_DEPTH];
    logic [PTR_W-1:0]      xq_wptr;
    logic [PTR_W-1:0]      xq_rptr;
    logic [CNT_W-1:0]      xq_count;
    logic                  xq_nonempty;

    logic [CNT_W-1:0]      xq_free;
    logic [CNT_W-1:0]      xcnt;
    logic                  prefix_ok;
    logic [NUM_RT-1:0]     fire;

    logic [NUM_RT*VLENB-1:0] vrf_strobe_d;
    logic [NUM_RT-1:0]     vrf_valid_d;
    logic [VLENB-1:0]      younger_mask;
    logic [PTR_W-1:0]      push_ptr [NUM_RT];
    logic [CNT_W-1:0]      push_cnt;
    logic                  pop;
    logic [CNT_W-1:0]      xq_count_d;
    logic                  trap_fire;
    logic [VCSR_W-1:0]     trap_vcsr;
    logic                  any_vxsat;

    assign xq_free      = CNT_W'(XQ_DEPTH) - xq_count;
    assign fire         = rob2rt_valid & rob2rt_ready;
    assign pop          = xq_nonempty & rt2xrf_ready;
    assign xq_count_d   = xq_count + push_cnt - CNT_W'(pop);
    assign rt2xrf_valid = xq_nonempty;
    assign rt2xrf_index = xq_index[xq_rptr];
    assign rt2xrf_data  = xq_data[xq_rptr];
    assign trap_busy    = (state == RT_TRAP_DRAIN);

    // Ready: contiguous untrapped prefix whose XRF writes fit in the FIFO's free space
    always_comb begin
        rob2rt_ready = '0;
        xcnt         = '0;
        prefix_ok    = 1'b1;
        for (int i = 0; i < NUM_RT; i++) begin
            xcnt            = xcnt + CNT_W'(rob2rt_wtype[i]);
            rob2rt_ready[i] = (state == RT_RUN) && prefix_ok && (xcnt <= xq_free);
            prefix_ok       = prefix_ok && rob2rt_valid[i] && !rob2rt_trap[i];
        end
    end

    // Per-slot resolution: WAW strobe masking, FIFO push slots, trap snapshot, vxsat
    always_comb begin
        vrf_strobe_d = '0;
        vrf_valid_d  = '0;
        younger_mask = '0;
        push_cnt     = '0;
        trap_fire    = 1'b0;
        trap_vcsr    = '0;
        any_vxsat    = 1'b0;
        for (int i = 0; i < NUM_RT; i++) begin
            younger_mask = '0;
            for (int j = 0; j < NUM_RT; j++) begin
                if ((j > i) && fire[j] && !rob2rt_wtype[j] &&
                    (rob2rt_index[j*IDX_W +: IDX_W] == rob2rt_index[i*IDX_W +: IDX_W])) begin
                    younger_mask = younger_mask | rob2rt_strobe[j*VLENB +: VLENB];
                end
            end
            if (fire[i] && !rob2rt_wtype[i]) begin
                vrf_strobe_d[i*VLENB +: VLENB] = rob2rt_strobe[i*VLENB +: VLENB] & ~younger_mask;
            end
            vrf_valid_d[i] = |vrf_strobe_d[i*VLENB +: VLENB];

            push_ptr[i] = xq_wptr + PTR_W'(push_cnt);
            if (fire[i] && rob2rt_wtype[i]) begin
                push_cnt = push_cnt + CNT_W'(1);
            end

            if (fire[i] && rob2rt_trap[i]) begin
                trap_fire = 1'b1;
                trap_vcsr = rob2rt_vcsr[i*VCSR_W +: VCSR_W];
            end
            if (fire[i] && rob2rt_vxsat[i]) begin
                any_vxsat = 1'b1;
            end
        end
    end

    // VRF write port: one-cycle registered copy of the resolved group
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rt2vrf_valid  <= '0;
            rt2vrf_index  <= '0;
            rt2vrf_data   <= '0;
            rt2vrf_strobe <= '0;
        end else begin
            rt2vrf_valid  <= vrf_valid_d;
            rt2vrf_index  <= rob2rt_index;
            rt2vrf_data   <= rob2rt_data;
            rt2vrf_strobe <= vrf_strobe_d;
        end
    end

    // XRF FIFO: multi-push in slot order, single pop at the head
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < XQ_DEPTH; k++) begin
                xq_index[k] <= '0;
                xq_data[k]  <= '0;
            end
            xq_wptr     <= '0;
            xq_rptr     <= '0;
            xq_count    <= '0;
            xq_nonempty <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RT; i++) begin
                if (fire[i] && rob2rt_wtype[i]) begin
                    xq_index[push_ptr[i]] <= rob2rt_index[i*IDX_W +: IDX_W];
                    xq_data[push_ptr[i]]  <= rob2rt_data[i*VLEN +: XLEN];
                end
            end
            xq_wptr     <= xq_wptr + PTR_W'(push_cnt);
            xq_rptr     <= xq_rptr + PTR_W'(pop);
            xq_count    <= xq_count_d;
            xq_nonempty <= (xq_count_d != '0);
        end
    end

    // Trap FSM: drain the XRF FIFO, then pulse the CSR update once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RT_RUN;
            rt2vcsr_valid <= 1'b0;
            rt2vcsr_data  <= '0;
        end else begin
            case (state)
                RT_RUN: begin
                    if (trap_fire) begin
                        state         <= RT_TRAP_DRAIN;
                        rt2vcsr_data  <= trap_vcsr;
                        rt2vcsr_valid <= (xq_count_d == '0);
                    end else begin
                        rt2vcsr_valid <= 1'b0;
                    end
                end
                RT_TRAP_DRAIN: begin
                    if (xq_count == '0) begin
                        state         <= RT_RUN;
                        rt2vcsr_valid <= 1'b0;
                    end else begin
                        rt2vcsr_valid <= (xq_count_d == '0);
                    end
                end
                default: begin
                    state         <= RT_RUN;
                    rt2vcsr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky saturation flag; a same-cycle set overrides the clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vxsat <= 1'b0;
        end else if (any_vxsat) begin
            vxsat <= 1'b1;
        end else if (vxsat_clr) begin
            vxsat <= 1'b0;
        end
    end

`ifdef RT_PERF_CNT_EN
    // Free-running retire and slot-0 stall counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            perf_retired <= perf_retired + 32'($countones(fire));
            if (rob2rt_valid[0] && !rob2rt_ready[0]) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rvv_backend_retire_pipe.sv
// Directed self-checking bench for rvv_backend_retire_pipe (default config).
module tb_rvv_backend_retire_pipe;

    localparam int unsigned NUM_RT   = 4;
    localparam int unsigned VLEN     = 128;
    localparam int unsigned VLENB    = VLEN / 8;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned VCSR_W   = 32;
    localparam int unsigned XQ_DEPTH = 8;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_RT-1:0]           valid;
    logic [NUM_RT-1:0]           wtype;
    logic [NUM_RT*IDX_W-1:0]     index;
    logic [NUM_RT*VLEN-1:0]      data;
    logic [NUM_RT*VLENB-1:0]     strobe;
    logic [NUM_RT-1:0]           trap;
    logic [NUM_RT-1:0]           vxs;
    logic [NUM_RT*VCSR_W-1:0]    vcsr;
    logic [NUM_RT-1:0]           ready;
    logic [NUM_RT-1:0]           vrf_valid;
    logic [NUM_RT*IDX_W-1:0]     vrf_index;
    logic [NUM_RT*VLEN-1:0]      vrf_data;
    logic [NUM_RT*VLENB-1:0]     vrf_strobe;
    logic                        xrf_valid;
    logic [IDX_W-1:0]            xrf_index;
    logic [XLEN-1:0]             xrf_data;
    logic                        xrf_ready;
    logic                        vcsr_valid;
    logic [VCSR_W-1:0]           vcsr_data;
    logic                        vxsat;
    logic                        vxsat_clr;
    logic                        trap_busy;

    int n_cmp;
    int n_err;

    rvv_backend_retire_pipe #(
        .NUM_RT(NUM_RT), .VLEN(VLEN), .XLEN(XLEN), .IDX_W(IDX_W),
        .VCSR_W(VCSR_W), .XQ_DEPTH(XQ_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rob2rt_valid  (valid),
        .rob2rt_wtype  (wtype),
        .rob2rt_index  (index),
        .rob2rt_data   (data),
        .rob2rt_strobe (strobe),
        .rob2rt_trap   (trap),
        .rob2rt_vxsat  (vxs),
        .rob2rt_vcsr   (vcsr),
        .rob2rt_ready  (ready),
        .rt2vrf_valid  (vrf_valid),
        .rt2vrf_index  (vrf_index),
        .rt2vrf_data   (vrf_data),
        .rt2vrf_strobe (vrf_strobe),
        .rt2xrf_valid  (xrf_valid),
        .rt2xrf_index  (xrf_index),
        .rt2xrf_data   (xrf_data),
        .rt2xrf_ready  (xrf_ready),
        .rt2vcsr_valid (vcsr_valid),
        .rt2vcsr_data  (vcsr_data),
        .vxsat         (vxsat),
        .vxsat_clr     (vxsat_clr),
        .trap_busy     (trap_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_slots();
        valid  = '0;
        wtype  = '0;
        index  = '0;
        data   = '0;
        strobe = '0;
        trap   = '0;
        vxs    = '0;
        vcsr   = '0;
    endtask

    task automatic set_slot(input int s, input logic wt, input logic [IDX_W-1:0] idx,
                            input logic [VLEN-1:0] d, input logic [VLENB-1:0] st,
                            input logic tr, input logic vx, input logic [VCSR_W-1:0] cs);
        valid[s]                    = 1'b1;
        wtype[s]                    = wt;
        index[s*IDX_W +: IDX_W]     = idx;
        data[s*VLEN +: VLEN]        = d;
        strobe[s*VLENB +: VLENB]    = st;
        trap[s]                     = tr;
        vxs[s]                      = vx;
        vcsr[s*VCSR_W +: VCSR_W]    = cs;
    endtask

    initial begin
        int  k;
        bit  drained;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        xrf_ready = 1'b0;
        vxsat_clr = 1'b0;
        clear_slots();

        // reset state
        repeat (3) @(negedge clk);
        check("rst_vrf_valid", 128'(vrf_valid), 128'h0);
        check("rst_xrf_valid", 128'(xrf_valid), 128'h0);
        check("rst_vcsr_valid", 128'(vcsr_valid), 128'h0);
        check("rst_vxsat", 128'(vxsat), 128'h0);
        check("rst_trap_busy", 128'(trap_busy), 128'h0);
        rst_n = 1'b1;
        #1 check("idle_ready", 128'(ready), 128'h1);

        // VRF WAW: indices 3,3,5,3 with full strobes
        @(negedge clk);
        set_slot(0, 1'b0, 5'd3, 128'hA0, 16'hFFFF, 1'b0, 1'b0, 32'h0);
        set_slot(1, 1'b0, 5'd3, 128'hA1, 16'hFFFF, 1'b0, 1'b0, 32'h0);
        set_slot(2, 1'b0, 5'd5, 128'hA2, 16'hFFFF, 1'b0, 1'b0, 32'h0);
        set_slot(3, 1'b0, 5'd3, 128'hA3, 16'hFFFF, 1'b0, 1'b0, 32'h0);
        #1 check("waw_ready", 128'(ready), 128'hF);
        @(negedge clk);
        check("waw_valid", 128'(vrf_valid), 128'hC);
        check("waw_strobe3", 128'(vrf_strobe[3*VLENB +: VLENB]), 128'hFFFF);
        check("waw_strobe2", 128'(vrf_strobe[2*VLENB +: VLENB]), 128'hFFFF);
        check("waw_strobe0", 128'(vrf_strobe[0*VLENB +: VLENB]), 128'h0);
        check("waw_data2", vrf_data[2*VLEN +: VLEN], 128'hA2);
        check("waw_index2", 128'(vrf_index[2*IDX_W +: IDX_W]), 128'd5);

        // partial strobe overlap on index 7
        clear_slots();
        set_slot(0, 1'b0, 5'd7, 128'hB0, 16'h00FF, 1'b0, 1'b0, 32'h0);
        set_slot(1, 1'b0, 5'd7, 128'hB1, 16'h0F0F, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("part_valid", 128'(vrf_valid), 128'h3);
        check("part_strobe0", 128'(vrf_strobe[0*VLENB +: VLENB]), 128'h00F0);
        check("part_strobe1", 128'(vrf_strobe[1*VLENB +: VLENB]), 128'h0F0F);

        // XRF bursts against a stalled port until the FIFO fills
        clear_slots();
        for (int s = 0; s < 4; s++)
            set_slot(s, 1'b1, 5'(s + 1), 128'(32'h100 + s), 16'h0, 1'b0, 1'b0, 32'h0);
        #1 check("xb1_ready", 128'(ready), 128'hF);
        @(negedge clk);
        check("xb1_vrf_quiet", 128'(vrf_valid), 128'h0);
        check("xb1_head_valid", 128'(xrf_valid), 128'h1);
        clear_slots();
        for (int s = 0; s < 4; s++)
            set_slot(s, 1'b1, 5'(s + 5), 128'(32'h100 + s + 4), 16'h0, 1'b0, 1'b0, 32'h0);
        #1 check("xb2_ready", 128'(ready), 128'hF);
        @(negedge clk);
        clear_slots();
        for (int s = 0; s < 4; s++)
            set_slot(s, 1'b1, 5'(s + 9), 128'h999, 16'h0, 1'b0, 1'b0, 32'h0);
        #1 check("xb3_ready", 128'(ready), 128'h0);
        check("xb3_head_idx", 128'(xrf_index), 128'd1);
        @(negedge clk);
        clear_slots();
        xrf_ready = 1'b1;
        for (int e = 0; e < 8; e++) begin
            #1;
            check("drain_valid", 128'(xrf_valid), 128'h1);
            check("drain_idx", 128'(xrf_index), 128'(e + 1));
            check("drain_data", 128'(xrf_data), 128'(32'h100 + e));
            @(negedge clk);
        end
        check("drain_empty", 128'(xrf_valid), 128'h0);

        // six queued entries leave room for only two more XRF slots
        xrf_ready = 1'b0;
        for (int s = 0; s < 4; s++)
            set_slot(s, 1'b1, 5'(s + 1), 128'(s), 16'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        clear_slots();
        set_slot(0, 1'b1, 5'd5, 128'h5, 16'h0, 1'b0, 1'b0, 32'h0);
        set_slot(1, 1'b1, 5'd6, 128'h6, 16'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        clear_slots();
        for (int s = 0; s < 4; s++)
            set_slot(s, 1'b1, 5'(s + 7), 128'(s + 7), 16'h0, 1'b0, 1'b0, 32'h0);
        #1 check("six_ready", 128'(ready), 128'h3);
        @(negedge clk);
        clear_slots();
        xrf_ready = 1'b1;
        drained = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (!xrf_valid) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("six_drained", 128'(drained), 128'h1);
        check("six_drain_cycles", 128'(k), 128'd8);

        // trap on slot 1 with two XRF entries queued
        xrf_ready = 1'b0;
        set_slot(0, 1'b1, 5'd20, 128'h20, 16'h0, 1'b0, 1'b0, 32'h0);
        set_slot(1, 1'b1, 5'd21, 128'h21, 16'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        clear_slots();
        xrf_ready = 1'b1;
        set_slot(0, 1'b0, 5'd9,  128'hC0, 16'hFFFF, 1'b0, 1'b0, 32'h11110000);
        set_slot(1, 1'b0, 5'd10, 128'hC1, 16'hFFFF, 1'b1, 1'b0, 32'hCAFE0001);
        set_slot(2, 1'b0, 5'd11, 128'hC2, 16'hFFFF, 1'b0, 1'b0, 32'h22220000);
        set_slot(3, 1'b0, 5'd12, 128'hC3, 16'hFFFF, 1'b0, 1'b0, 32'h33330000);
        #1 check("trap_ready", 128'(ready), 128'h3);
        check("trap_pre_busy", 128'(trap_busy), 128'h0);
        @(negedge clk);
        check("trap_vrf_valid", 128'(vrf_valid), 128'h3);
        check("trap_busy_c1", 128'(trap_busy), 128'h1);
        check("trap_vcsr_c1", 128'(vcsr_valid), 128'h0);
        clear_slots();
        set_slot(0, 1'b0, 5'd13, 128'hD0, 16'hFFFF, 1'b0, 1'b0, 32'h0);
        #1 check("trap_ready_c1", 128'(ready), 128'h0);
        @(negedge clk);
        check("trap_busy_c2", 128'(trap_busy), 128'h1);
        check("trap_vcsr_c2", 128'(vcsr_valid), 128'h1);
        check("trap_vcsr_data", 128'(vcsr_data), 128'hCAFE0001);
        check("trap_fifo_empty", 128'(xrf_valid), 128'h0);
        @(negedge clk);
        check("trap_busy_c3", 128'(trap_busy), 128'h0);
        check("trap_vcsr_c3", 128'(vcsr_valid), 128'h0);
        check("trap_ready_c3", 128'(ready), 128'h3);
        clear_slots();

        // trap with an empty FIFO pulses on the very next cycle
        @(negedge clk);
        set_slot(0, 1'b0, 5'd14, 128'hE0, 16'hFFFF, 1'b1, 1'b0, 32'h00001234);
        set_slot(1, 1'b0, 5'd15, 128'hE1, 16'hFFFF, 1'b0, 1'b0, 32'h0);
        #1 check("etrap_ready", 128'(ready), 128'h1);
        @(negedge clk);
        clear_slots();
        check("etrap_busy", 128'(trap_busy), 128'h1);
        check("etrap_vcsr", 128'(vcsr_valid), 128'h1);
        check("etrap_vcsr_data", 128'(vcsr_data), 128'h1234);
        @(negedge clk);
        check("etrap_busy_end", 128'(trap_busy), 128'h0);
        check("etrap_vcsr_end", 128'(vcsr_valid), 128'h0);

        // reset while draining: FIFO dropped, no CSR pulse
        xrf_ready = 1'b0;
        set_slot(0, 1'b1, 5'd16, 128'h16, 16'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        clear_slots();
        set_slot(0, 1'b0, 5'd17, 128'h17, 16'hFFFF, 1'b1, 1'b0, 32'h5555);
        @(negedge clk);
        clear_slots();
        check("mid_busy", 128'(trap_busy), 128'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 128'(trap_busy), 128'h0);
        check("mid_rst_xrf", 128'(xrf_valid), 128'h0);
        check("mid_rst_vcsr", 128'(vcsr_valid), 128'h0);
        rst_n = 1'b1;
        xrf_ready = 1'b1;
        @(negedge clk);
        check("mid_post_vcsr", 128'(vcsr_valid), 128'h0);
        check("mid_post_xrf", 128'(xrf_valid), 128'h0);

        // vxsat: set beats clear in the same cycle, clear alone clears
        set_slot(0, 1'b0, 5'd1, 128'h1, 16'h000F, 1'b0, 1'b0, 32'h0);
        set_slot(1, 1'b0, 5'd2, 128'h2, 16'h000F, 1'b0, 1'b0, 32'h0);
        set_slot(2, 1'b0, 5'd3, 128'h3, 16'h000F, 1'b0, 1'b1, 32'h0);
        vxsat_clr = 1'b1;
        @(negedge clk);
        check("vxsat_set_wins", 128'(vxsat), 128'h1);
        clear_slots();
        @(negedge clk);
        check("vxsat_cleared", 128'(vxsat), 128'h0);
        vxsat_clr = 1'b0;
        @(negedge clk);
        check("vxsat_stays_clr", 128'(vxsat), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
